// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Multi-cycle fetch controller that owns the program counter. It issues
//   instruction-memory requests over a valid/ready handshake and hands each
//   fetched word to decode. After every accepted instruction the PC advances
//   by +4, or moves to a branch target when a redirect is taken.
//
// Parameters
//   XLEN          PC / address width
//   RESET_VECTOR  PC value after reset
//   MAX_WAIT      response-wait cycles before timeout (1..255)
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   start, halt                 begin fetching / stop at next fetch boundary
//   branch_taken, branch_target one-cycle redirect pulse and its target
//   imem_req_*                  request channel (valid/ready, addr = pc)
//   imem_resp_*                 one-cycle response strobe and instruction word
//   instr_valid/ready, instr,   instruction offered to decode, and its address
//   instr_pc
//   pc, state                   current PC and FSM state code
//   timeout_err                 sticky: response wait exceeded MAX_WAIT
//
// Build option
//   PC_MISALIGN_CHECK_EN  adds the sticky output misalign_err. A redirect to a
//                         target with nonzero bits [1:0] enters TRAP. When the
//                         option is off, target bits [1:0] are cleared before use.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     MAX_WAIT     = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            timeout_err
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_ERROR   = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [7:0]      WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  state_t          cur_q, nxt;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            tmo_q, tmo_d;

  logic            redir_ok;
  logic            redir_any;
  logic [XLEN-1:0] tgt_in;
  logic [XLEN-1:0] redir_addr;

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic misaligned;
  assign tgt_in     = branch_target;
  assign misaligned = redir_ok && branch_taken && (branch_target[1:0] != 2'b00);
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target[1:0];
  assign tgt_in         = {branch_target[XLEN-1:2], 2'b00};
`endif

  // Redirects are only honoured while a fetch is in progress.
  assign redir_ok   = (cur_q == S_FETCH) || (cur_q == S_WAIT) || (cur_q == S_DELIVER);
  assign redir_any  = pend_q || (redir_ok && branch_taken);
  // When a redirect was already pending, a pulse in the current cycle takes priority.
  assign redir_addr = branch_taken ? tgt_in : tgt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q   <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      tmo_q   <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      cur_q   <= nxt;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      tmo_q   <= tmo_d;
`ifdef PC_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    nxt     = cur_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    tmo_d   = tmo_q;
`ifdef PC_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif

    if (redir_ok && branch_taken) begin
      pend_d = 1'b1;
      tgt_d  = tgt_in;
    end

    case (cur_q)
      S_IDLE: begin
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_req_ready) begin
          nxt   = S_WAIT;
          cnt_d = '0;
        end else if (halt) begin
          // The request is withdrawn, but a pending redirect still updates the PC.
          nxt = S_IDLE;
          if (redir_any) begin
            pc_d   = redir_addr;
            pend_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          cnt_d = '0;
          if (redir_any) begin
            // The response belongs to the old stream: drop it and refetch at the target.
            nxt    = S_FETCH;
            pc_d   = redir_addr;
            pend_d = 1'b0;
          end else begin
            nxt     = S_DELIVER;
            instr_d = imem_resp_data;
            ipc_d   = pc_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == WAIT_LIMIT) begin
            nxt   = S_ERROR;
            tmo_d = 1'b1;
          end
        end
      end
      S_DELIVER: begin
        if (instr_ready) begin
          pc_d   = redir_any ? redir_addr : pc_q + PC_STEP;
          pend_d = 1'b0;
          nxt    = halt ? S_IDLE : S_FETCH;
        end else if (redir_any) begin
          // Flush the instruction that has not been accepted yet.
          pc_d   = redir_addr;
          pend_d = 1'b0;
          nxt    = S_FETCH;
        end
      end
      S_ERROR, S_TRAP: begin
      end
      default: nxt = S_IDLE;
    endcase

`ifdef PC_MISALIGN_CHECK_EN
    if (misaligned) begin
      nxt    = S_TRAP;
      pc_d   = branch_target;
      pend_d = 1'b0;
      mis_d  = 1'b1;
    end
`endif
  end

  assign imem_req_valid = (cur_q == S_FETCH);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (cur_q == S_DELIVER);
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign pc             = pc_q;
  assign state          = cur_q;
  assign timeout_err    = tmo_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign_err   = mis_q;
`endif

endmodule
